// File: rtl/mips_alu_pkg.sv
// Shared execute-stage definitions: ALU and mult/div funct codes plus the
// mult/div sequencer state encoding.
package mips_alu_pkg;

    // Combinational ALU funct codes
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // Multiply/divide and HI/LO move funct codes
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle of the mult/div unit.
//   slave  : the unit (receives in_valid/funct/rs_val/rt_val, drives the rest)
//   master : the pipeline side
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             out_valid;
    logic [WIDTH-1:0] rdata;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, funct, rs_val, rt_val,
        input  in_ready, out_valid, rdata, done, illegal, hi, lo
    );

    modport slave (
        input  in_valid, funct, rs_val, rt_val,
        output in_ready, out_valid, rdata, done, illegal, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, q} with operand opb.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i/q_i/opb_i : current accumulator, shift register, operand
//   acc_c_o/q_c_o   : next accumulator and shift register (combinational)
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] acc_c_o,
    output logic [WIDTH-1:0] q_c_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + {1'b0, opb_i};
        rem     = {acc_i, q_i[WIDTH-1]};
        diff    = rem - {1'b0, opb_i};
        acc_c_o = acc_i;
        q_c_o   = q_i;
        if (is_div_i) begin
            // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow.
            if (!diff[WIDTH]) begin
                acc_c_o = diff[WIDTH-1:0];
                q_c_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_c_o = rem[WIDTH-1:0];
                q_c_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Multiplier LSB gates the add; the product shifts right into q.
            if (q_i[0]) begin
                acc_c_o = sum[WIDTH:1];
                q_c_o   = {sum[0], q_i[WIDTH-1:1]};
            end else begin
                acc_c_o = {1'b0, acc_i[WIDTH-1:1]};
                q_c_o   = {acc_i[0], q_i[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request (in_valid/funct/rs_val/rt_val, in_ready) and results
//              (out_valid/rdata for MFHI/MFLO, done, illegal, hi, lo)
module mips_muldiv_unit
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_muldiv_unit_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0]   step_acc, step_q;
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .opb_i    (opb_q),
        .acc_c_o  (step_acc),
        .q_c_o    (step_q)
    );

    // Operand magnitudes and result signs for the signed variants
    always_comb begin
        signed_op = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
        a_neg     = signed_op && bus.rs_val[WIDTH-1];
        b_neg     = signed_op && bus.rt_val[WIDTH-1];
        mag_a     = a_neg ? -bus.rs_val : bus.rs_val;
        mag_b     = b_neg ? -bus.rt_val : bus.rt_val;
    end

    // Sign-corrected results; MIN/-1 falls out naturally as MIN with remainder 0
    always_comb begin
        prod_s = neg_q_q ? -{acc_q, q_q} : {acc_q, q_q};
        quot_s = neg_q_q ? -q_q : q_q;
        rem_s  = neg_r_q ? -acc_q : acc_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            opb_q       <= '0;
            a_raw_q     <= '0;
            is_div_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            opb_q       <= opb_d;
            a_raw_q     <= a_raw_d;
            is_div_q    <= is_div_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            dbz_q       <= dbz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        q_d         = q_q;
        opb_d       = opb_q;
        a_raw_d     = a_raw_q;
        is_div_d    = is_div_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dbz_d       = dbz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.funct)
                        FUNCT_MTHI: hi_d = bus.rs_val;
                        FUNCT_MTLO: lo_d = bus.rs_val;
                        FUNCT_MFHI: begin
                            rdata_d     = hi_q;
                            out_valid_d = 1'b1;
                        end
                        FUNCT_MFLO: begin
                            rdata_d     = lo_q;
                            out_valid_d = 1'b1;
                        end
                        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                            state_d  = CALC;
                            cnt_d    = CNT_W'(WIDTH - 1);
                            is_div_d = bus.funct[1];
                            acc_d    = '0;
                            // Divide shifts the dividend through q; multiply shifts the multiplier.
                            q_d      = bus.funct[1] ? mag_a : mag_b;
                            opb_d    = bus.funct[1] ? mag_b : mag_a;
                            neg_q_d  = a_neg ^ b_neg;
                            neg_r_d  = a_neg;
                            dbz_d    = bus.funct[1] && (bus.rt_val == '0);
                            a_raw_d  = bus.rs_val;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            CALC: begin
                acc_d = step_acc;
                q_d   = step_q;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_s;
                end else if (dbz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized self-checking bench for mips_muldiv_unit against an arithmetic
// reference model of HI/LO behaviour.
module tb_mips_muldiv_unit;
    import mips_alu_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: HI/LO after a mult/div from the arithmetic definition
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      ps;
        logic [63:0] pu;
        h = m_hi;
        l = m_lo;
        case (f)
            FUNCT_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                {h, l} = 64'(ps);
            end
            FUNCT_MULTU: begin
                pu = 64'(a) * 64'(b);
                {h, l} = pu;
            end
            FUNCT_DIV: begin
                if (b == 0) begin h = a; l = '1; end
                else if (a == MIN && b == 32'hFFFF_FFFF) begin h = 0; l = MIN; end
                else begin
                    l = 32'($signed(a) / $signed(b));
                    h = 32'($signed(a) % $signed(b));
                end
            end
            FUNCT_DIVU: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Present one request for a single accept edge; returns #1 after that edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.funct    = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_muldiv(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n, ready_bad, hl_bad;
        model(f, a, b, eh, el);
        issue(f, a, b);
        n = 1;
        ready_bad = 0;
        hl_bad = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.in_ready !== 1'b0) ready_bad++;
            if (bus.hi !== m_hi || bus.lo !== m_lo) hl_bad++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(W + 2));
        chk({tag, "_busy_ready"}, 64'(ready_bad), 64'd0);
        chk({tag, "_hilo_stable"}, 64'(hl_bad), 64'd0);
        chk({tag, "_ready_done"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] xh, input logic [31:0] xl);
        do_muldiv(tag, f, a, b);
        chk({tag, "_hi_const"}, 64'(bus.hi), 64'(xh));
        chk({tag, "_lo_const"}, 64'(bus.lo), 64'(xl));
    endtask

    task automatic do_move(input logic [5:0] f, input logic [31:0] a);
        issue(f, a, 32'd0);
        case (f)
            FUNCT_MTHI: begin m_hi = a; chk("mthi_hi", 64'(bus.hi), 64'(a)); end
            FUNCT_MTLO: begin m_lo = a; chk("mtlo_lo", 64'(bus.lo), 64'(a)); end
            FUNCT_MFHI: begin
                chk("mfhi_valid", 64'(bus.out_valid), 64'd1);
                chk("mfhi_rdata", 64'(bus.rdata), 64'(m_hi));
            end
            default: begin
                chk("mflo_valid", 64'(bus.out_valid), 64'd1);
                chk("mflo_rdata", 64'(bus.rdata), 64'(m_lo));
            end
        endcase
    endtask

    initial begin
        logic [5:0] legal [8];
        logic [5:0] bad [3];
        int hits;
        legal = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                  FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO};
        bad   = '{FUNCT_ADD, FUNCT_AND, 6'b000000};

        bus.in_valid = 1'b0;
        bus.funct    = '0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_outs", {60'd0, bus.out_valid, bus.done, bus.illegal, 1'b0}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);

        directed("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        directed("mult_neg", FUNCT_MULT, -32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        directed("div_neg", FUNCT_DIV, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("div_ovf", FUNCT_DIV, MIN, 32'hFFFF_FFFF, 32'h0, MIN);
        directed("divu_zero", FUNCT_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        directed("div_zero", FUNCT_DIV, -32'd9, 32'd0, -32'd9, 32'hFFFF_FFFF);

        // MTHI then MFHI back to back
        bus.in_valid = 1'b1;
        bus.funct    = FUNCT_MTHI;
        bus.rs_val   = 32'h1234_5678;
        @(posedge clk); #1;
        m_hi = 32'h1234_5678;
        chk("b2b_hi", 64'(bus.hi), 64'h1234_5678);
        bus.funct = FUNCT_MFHI;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_rdata", 64'(bus.rdata), 64'h1234_5678);
        @(posedge clk); #1;
        chk("b2b_valid_drop", 64'(bus.out_valid), 64'd0);

        // MTLO held during a busy MULTU is ignored until ready returns
        bus.in_valid = 1'b1;
        bus.funct    = FUNCT_MULTU;
        bus.rs_val   = 32'h10;
        bus.rt_val   = 32'h10;
        @(posedge clk); #1;
        bus.funct  = FUNCT_MTLO;
        bus.rs_val = 32'hDEAD_BEEF;
        hits = 0;
        while (bus.in_ready !== 1'b1 && hits < 60) begin
            @(posedge clk); #1;
            hits++;
        end
        chk("hold_done", 64'(bus.done), 64'd1);
        chk("hold_lo", 64'(bus.lo), 64'h100);
        chk("hold_hi", 64'(bus.hi), 64'h0);
        m_hi = 32'h0;
        @(posedge clk); #1;
        m_lo = 32'hDEAD_BEEF;
        chk("hold_mtlo", 64'(bus.lo), 64'hDEAD_BEEF);
        bus.funct = FUNCT_ADD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("ill_pulse", 64'(bus.illegal), 64'd1);
        chk("ill_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        chk("ill_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("ill_once", 64'(bus.illegal), 64'd0);

        // Randomized mix against the model
        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            a = pick();
            b = pick();
            if ($urandom_range(0, 9) == 0) begin
                f = bad[$urandom_range(0, 2)];
                issue(f, a, b);
                chk("rnd_illegal", 64'(bus.illegal), 64'd1);
                chk("rnd_ill_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
            end else begin
                f = legal[$urandom_range(0, 7)];
                if (f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU)
                    do_muldiv("rnd", f, a, b);
                else
                    do_move(f, a);
            end
        end

        // Reset mid-DIVU aborts silently
        issue(FUNCT_DIVU, $urandom(), 32'($urandom_range(1, 1000)));
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_ready", 64'(bus.in_ready), 64'd1);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) hits++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 64'(hits), 64'd0);
        do_move(FUNCT_MFLO, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage. It is the parametrised successor to the ALU: same funct-code decoding, extended to multi-cycle MULT/MULTU/DIV/DIVU plus the MFHI/MFLO/MTHI/MTLO moves, with a valid/ready handshake so the pipeline can stall while it is busy.

## Interface
- WIDTH, 32: operand, HI and LO width (≥4).
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived, not overridden).

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; equals state==IDLE.
- funct  in  6  MIPS funct code.
- rs_val  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  WIDTH  operand B (divisor / multiplier).
- out_valid  out  1  one-cycle pulse: rdata valid (MFHI/MFLO only).
- rdata  out  WIDTH  HI or LO read value.
- done  out  1  one-cycle pulse: mult/div result committed to HI/LO.
- illegal  out  1  one-cycle pulse: accepted funct not supported.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Accept = in_valid && in_ready. Requests presented while in_ready=0 are ignored; no queueing.
- Funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Any other code: accepted, illegal pulses next cycle, no state change.
- MTHI/MTLO: rs_val is written to hi/lo on the accept edge. Unit stays IDLE.
- MFHI/MFLO: rdata ← hi/lo on the accept edge, out_valid=1 the following cycle. Unit stays IDLE.
- MULT/DIV states: IDLE → CALC (WIDTH cycles) → FIX (1 cycle) → IDLE.
  - Signed ops convert operands to magnitudes on accept and record the result signs.
  - CALC performs one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle. The counter runs from WIDTH-1 down to 0.
  - FIX applies signs and writes hi/lo. Multiply: {hi,lo} is the 2·WIDTH product. Divide: lo is the quotient, hi the remainder. The remainder takes the sign of the dividend; the quotient truncates toward zero.
- Divide by zero (DIV or DIVU): lo = all ones, hi = rs_val. Latency is unchanged.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- rst at any time: state=IDLE, hi=lo=rdata=0, out_valid=done=illegal=0. Any operation in flight is aborted silently.

## Timing
- Reset values: in_ready=1, all other outputs 0.
- MTHI/MTLO: new value is visible on hi/lo in the cycle after accept. A back-to-back MFHI/MFLO sees it.
- MFHI/MFLO: latency 1, and a new request can be accepted in the same cycle as out_valid.
- MULT/DIV timing, counting the accept edge as E0:
  - in_ready=0 from the cycle after E0.
  - The last CALC step occurs at E_WIDTH.
  - FIX commits at E_(WIDTH+1).
  - In the cycle after E_(WIDTH+1), done=1, hi/lo hold the new values, and in_ready=1.
  - Result: WIDTH+2 cycles from accept to done, and a new request can be accepted in the done cycle.
- hi/lo do not change during CALC; readers see the old values until FIX.

## Structure
- The shared package mips_alu_pkg holds:
  - the funct localparams above, added beside the existing ALU codes (ADD 100000, AND 100100, …);
  - the state enum IDLE/CALC/FIX.
- Sub-module muldiv_step is natural. It is combinational and implements one iteration (shift-add or restoring subtract) on {acc, q, operand}. The counter, sign handling and HI/LO registers stay in the top level.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done exactly 34 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; in_ready low for cycles 1–33.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- DIVU 7 / 0 → lo=0xFFFFFFFF, hi=7, same 34-cycle latency.
- MTHI 0x12345678, then MFHI on the next cycle → hi=0x12345678; out_valid=1 with rdata=0x12345678 one cycle later.
- MULTU 0x10 × 0x10 with in_valid held and funct=MTLO during busy → MTLO ignored until in_ready returns. Then funct=100000 → illegal pulses once, hi/lo unchanged.
- rst asserted at CALC iteration 10 of a DIVU → next cycle hi=lo=0, in_ready=1; done never pulses for the aborted operation.
